// File: rtl/adam_mem_to_axil_pkg.sv
// adam_mem_to_axil_pkg
// Shared definitions for the memory-port to AXI-Lite initiator bridge.
// Contents:
//   RESP_*      AXI-Lite response codes
//   state_e     bridge FSM states
//   ADDR_T/DATA_T/STRB_T   default-configuration bus types
//   resp_is_err helper that folds SLVERR/DECERR into one error flag
package adam_mem_to_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Explicit encodings keep the state values stable for older tooling
  // and waveform decoders that expect fixed numbers.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_WRESP  = 3'd2,
    ST_RADDR  = 3'd3,
    ST_RDATA  = 3'd4,
    ST_PAUSED = 3'd5
  } state_e;

  localparam int CFG_ADDR_WIDTH = 32;
  localparam int CFG_DATA_WIDTH = 32;
  localparam int CFG_STRB_WIDTH = CFG_DATA_WIDTH / 8;

  typedef logic [CFG_ADDR_WIDTH-1:0] ADDR_T;
  typedef logic [CFG_DATA_WIDTH-1:0] DATA_T;
  typedef logic [CFG_STRB_WIDTH-1:0] STRB_T;

  // Both slave error and decode error are reported as a single error bit.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/adam_mem_to_axil.sv
// adam_mem_to_axil
// Initiator bridge from a single-port memory request interface to an
// AXI-Lite master. One transaction is outstanding at a time; a pause
// handshake lets the owner quiesce the bridge between transactions.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pause_req / pause_ack    quiesce request / acknowledge
//   mem_req/gnt/addr/we/be/wdata   memory-style request side
//   mem_rvalid/rdata/err     one-cycle response pulse with read data / error
//   aw_*, w_*, b_*           AXI-Lite write channels
//   ar_*, r_*                AXI-Lite read channels
module adam_mem_to_axil
  import adam_mem_to_axil_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [2:0]  PROT       = 3'b000,
  localparam int         STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause_req,
  output logic                  pause_ack,
  input  logic                  mem_req,
  output logic                  mem_gnt,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_we,
  input  logic [STRB_WIDTH-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rvalid,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_err,
  output logic [ADDR_WIDTH-1:0] aw_addr,
  output logic [2:0]            aw_prot,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [STRB_WIDTH-1:0] w_strb,
  output logic                  w_valid,
  input  logic                  w_ready,
  input  logic [1:0]            b_resp,
  input  logic                  b_valid,
  output logic                  b_ready,
  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic [2:0]            ar_prot,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [1:0]            r_resp,
  input  logic                  r_valid,
  output logic                  r_ready
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [STRB_WIDTH-1:0] be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  aw_pend_q, aw_pend_d;
  logic                  w_pend_q, w_pend_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  // Next-state and grant logic. Grants are only possible in IDLE and a
  // pending pause always beats a pending request. The AW and W channels
  // are tracked by separate pending flags so that each can retire on its
  // own ready; the FSM leaves WR only once both have retired. The response
  // pulse defaults low so it lasts exactly one cycle.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_gnt   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pause_req) begin
          state_d = ST_PAUSED;
        end else if (mem_req) begin
          mem_gnt   = 1'b1;
          addr_d    = mem_addr;
          be_d      = mem_be;
          wdata_d   = mem_wdata;
          aw_pend_d = mem_we;
          w_pend_d  = mem_we;
          state_d   = mem_we ? ST_WR : ST_RADDR;
        end
      end
      ST_WR: begin
        if (aw_ready) aw_pend_d = 1'b0;
        if (w_ready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        if (b_valid) begin
          rvalid_d = 1'b1;
          err_d    = resp_is_err(b_resp);
          state_d  = ST_IDLE;
        end
      end
      ST_RADDR: begin
        if (ar_ready) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (r_valid) begin
          rvalid_d = 1'b1;
          rdata_d  = r_data;
          err_d    = resp_is_err(r_resp);
          state_d  = ST_IDLE;
        end
      end
      ST_PAUSED: begin
        if (!pause_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request and response registers. Reset drops the FSM to IDLE
  // immediately, which also kills every channel valid because those are
  // decoded from the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign aw_addr    = addr_q;
  assign aw_prot    = PROT;
  assign aw_valid   = (state_q == ST_WR) && aw_pend_q;
  assign w_data     = wdata_q;
  assign w_strb     = be_q;
  assign w_valid    = (state_q == ST_WR) && w_pend_q;
  assign b_ready    = (state_q == ST_WRESP);
  assign ar_addr    = addr_q;
  assign ar_prot    = PROT;
  assign ar_valid   = (state_q == ST_RADDR);
  assign r_ready    = (state_q == ST_RDATA);
  assign pause_ack  = (state_q == ST_PAUSED);
  assign mem_rvalid = rvalid_q;
  assign mem_rdata  = rdata_q;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_adam_mem_to_axil.sv
// tb_adam_mem_to_axil
// Self-checking bench for adam_mem_to_axil. A transaction-level model
// (outstanding transaction, per-channel handshake-done flags, pause flag,
// pending response) predicts every DUT output each cycle; directed scenarios
// pin latency, hold times, error mapping, pause and reset with literal values;
// a randomized phase drives random requests, slave timing and pauses.
module tb_adam_mem_to_axil;
  import adam_mem_to_axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pause_req = 1'b0;
  logic        pause_ack;
  logic        mem_req = 1'b0;
  logic        mem_gnt;
  logic [31:0] mem_addr = '0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_be = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] aw_addr;
  logic [2:0]  aw_prot;
  logic        aw_valid;
  logic        aw_ready = 1'b0;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic [1:0]  b_resp = 2'b00;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [31:0] ar_addr;
  logic [2:0]  ar_prot;
  logic        ar_valid;
  logic        ar_ready = 1'b0;
  logic [31:0] r_data = '0;
  logic [1:0]  r_resp = 2'b00;
  logic        r_valid = 1'b0;
  logic        r_ready;

  adam_mem_to_axil #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .PROT      (3'b000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pause_req (pause_req),
    .pause_ack (pause_ack),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err),
    .aw_addr   (aw_addr),
    .aw_prot   (aw_prot),
    .aw_valid  (aw_valid),
    .aw_ready  (aw_ready),
    .w_data    (w_data),
    .w_strb    (w_strb),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .b_resp    (b_resp),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .ar_addr   (ar_addr),
    .ar_prot   (ar_prot),
    .ar_valid  (ar_valid),
    .ar_ready  (ar_ready),
    .r_data    (r_data),
    .r_resp    (r_resp),
    .r_valid   (r_valid),
    .r_ready   (r_ready)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  bit          m_out, m_we, m_aw_done, m_w_done, m_ar_done, m_ack, m_rv;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        m_err;

  bit          gnt_seen = 0;
  bit          ack_prev = 0;
  int unsigned gnt_cycle = 0;
  int unsigned rvalid_cycle = 0;
  int unsigned ack_rise_cycle = 0;
  int          aw_cnt = 0;
  int          w_cnt = 0;
  int          b_cnt = 0;
  int          rv_cnt = 0;

  // Cycle counter used to measure latencies between observed events.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and comparison, evaluated mid-cycle when inputs and
  // combinational outputs are settled. The model only knows: is a
  // transaction outstanding, which of its handshakes are done, is the bridge
  // paused, and is a response due this cycle. It then advances itself to
  // what must hold after the coming rising edge.
  always @(negedge clk) begin : cmp
    bit idle, e_gnt, e_awv, e_wv, e_bred, e_arv, e_rred, hs_b, hs_r, n_ack;
    if (rst) begin
      m_out = 0; m_we = 0; m_aw_done = 0; m_w_done = 0; m_ar_done = 0;
      m_ack = 0; m_rv = 0; m_addr = '0; m_wdata = '0; m_be = '0;
      m_rdata = '0; m_err = 1'b0;
    end
    idle   = !m_out && !m_ack;
    e_gnt  = idle && mem_req && !pause_req;
    e_awv  = m_out && m_we && !m_aw_done;
    e_wv   = m_out && m_we && !m_w_done;
    e_bred = m_out && m_we && m_aw_done && m_w_done;
    e_arv  = m_out && !m_we && !m_ar_done;
    e_rred = m_out && !m_we && m_ar_done;

    checkOutput("mem_gnt", mem_gnt, e_gnt);
    checkOutput("aw_valid", aw_valid, e_awv);
    checkOutput("w_valid", w_valid, e_wv);
    checkOutput("b_ready", b_ready, e_bred);
    checkOutput("ar_valid", ar_valid, e_arv);
    checkOutput("r_ready", r_ready, e_rred);
    checkOutput("pause_ack", pause_ack, m_ack);
    checkOutput("mem_rvalid", mem_rvalid, m_rv);
    checkOutput("mem_rdata", mem_rdata, m_rdata);
    if (m_rv) checkOutput("mem_err", mem_err, m_err);
    if (e_awv) begin
      checkOutput("aw_addr", aw_addr, m_addr);
      checkOutput("aw_prot", aw_prot, 3'b000);
    end
    if (e_wv) begin
      checkOutput("w_data", w_data, m_wdata);
      checkOutput("w_strb", w_strb, m_be);
    end
    if (e_arv) begin
      checkOutput("ar_addr", ar_addr, m_addr);
      checkOutput("ar_prot", ar_prot, 3'b000);
    end

    if (mem_gnt) begin gnt_seen = 1; gnt_cycle = cyc; end
    if (mem_rvalid) begin rv_cnt++; rvalid_cycle = cyc; end
    if (aw_valid) aw_cnt++;
    if (w_valid) w_cnt++;
    if (b_valid && b_ready) b_cnt++;
    if (pause_ack && !ack_prev) ack_rise_cycle = cyc;
    ack_prev = pause_ack;

    if (!rst) begin
      hs_b  = e_bred && b_valid;
      hs_r  = e_rred && r_valid;
      n_ack = pause_req && (idle || m_ack);
      m_rv  = hs_b || hs_r;
      if (hs_r) begin
        m_rdata = r_data;
        m_err   = (r_resp == RESP_SLVERR) || (r_resp == RESP_DECERR);
      end
      if (hs_b) m_err = (b_resp == RESP_SLVERR) || (b_resp == RESP_DECERR);
      if (e_awv && aw_ready) m_aw_done = 1;
      if (e_wv && w_ready) m_w_done = 1;
      if (e_arv && ar_ready) m_ar_done = 1;
      if (hs_b || hs_r) m_out = 0;
      if (e_gnt) begin
        m_out = 1; m_we = mem_we; m_addr = mem_addr; m_be = mem_be;
        m_wdata = mem_wdata; m_aw_done = 0; m_w_done = 0; m_ar_done = 0;
      end
      m_ack = n_ack;
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setSlave(input logic awr, input logic wr, input logic arr,
                          input logic bv, input logic rv);
    aw_ready = awr; w_ready = wr; ar_ready = arr; b_valid = bv; r_valid = rv;
  endtask

  // Holds a request until it is granted, then drops it on the next cycle.
  task automatic issueReq(input logic we, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] d,
                          input int budget);
    bit got = 0;
    mem_req = 1'b1; mem_we = we; mem_addr = a; mem_be = be; mem_wdata = d;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (mem_gnt === 1'b1) got = 1;
      @(posedge clk);
      #1;
    end
    mem_req = 1'b0;
    if (!got) checkOutput("grant_timeout", 0, 1);
  endtask

  // Waits for the next response pulse; returns just after mid-cycle.
  task automatic waitResp(input int budget);
    int snap = rv_cnt;
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      #1;
      if (rv_cnt != snap) got = 1;
    end
    if (!got) checkOutput("resp_timeout", 0, 1);
  endtask

  // One cycle of random traffic: slave timing and response codes, a held
  // memory request replaced once granted, and slow pause toggling.
  task automatic applyStimulus();
    aw_ready = ($urandom_range(0, 3) != 0);
    w_ready  = ($urandom_range(0, 3) != 0);
    ar_ready = ($urandom_range(0, 3) != 0);
    b_valid  = ($urandom_range(0, 2) != 0);
    r_valid  = ($urandom_range(0, 2) != 0);
    b_resp   = 2'($urandom_range(0, 3));
    r_resp   = 2'($urandom_range(0, 3));
    r_data   = $urandom;
    if (mem_req && gnt_seen) mem_req = 1'b0;
    gnt_seen = 0;
    if (!mem_req && $urandom_range(0, 2) == 0) begin
      mem_req   = 1'b1;
      mem_we    = 1'($urandom_range(0, 1));
      mem_addr  = $urandom;
      mem_be    = 4'($urandom);
      mem_wdata = $urandom;
    end
    if ($urandom_range(0, 29) == 0) pause_req = !pause_req;
  endtask

  // Last-resort guard so a stuck DUT can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by the randomized phase and the summary.
  initial begin : main
    int snap;
    stepCycle();
    stepCycle();
    @(negedge clk);
    checkOutput("reset_aw_valid", aw_valid, 0);
    checkOutput("reset_ar_valid", ar_valid, 0);
    checkOutput("reset_mem_rvalid", mem_rvalid, 0);
    checkOutput("reset_mem_rdata", mem_rdata, 32'h0);
    checkOutput("reset_pause_ack", pause_ack, 0);
    stepCycle();
    rst = 1'b0;
    stepCycle();

    $display("[TB] read with immediate slave");
    setSlave(1, 1, 1, 1, 1);
    r_data = 32'hDEADBEEF; r_resp = RESP_OKAY;
    issueReq(1'b0, 32'h0000_0040, 4'hF, 32'h0, 10);
    waitResp(20);
    checkOutput("read_latency", rvalid_cycle - gnt_cycle, 3);
    checkOutput("read_rdata", mem_rdata, 32'hDEADBEEF);
    checkOutput("read_err", mem_err, 0);
    stepCycle();

    $display("[TB] write with late aw_ready");
    setSlave(0, 1, 1, 1, 1);
    b_resp = RESP_OKAY;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; snap = rv_cnt;
    issueReq(1'b1, 32'h0000_1000, 4'b0101, 32'hCAFEF00D, 10);
    stepCycle();
    stepCycle();
    stepCycle();
    aw_ready = 1'b1;
    waitResp(20);
    stepCycle();
    stepCycle();
    checkOutput("wr_aw_cycles", aw_cnt, 4);
    checkOutput("wr_w_cycles", w_cnt, 1);
    checkOutput("wr_b_handshakes", b_cnt, 1);
    checkOutput("wr_rvalid_pulses", rv_cnt - snap, 1);
    checkOutput("wr_rdata_kept", mem_rdata, 32'hDEADBEEF);

    $display("[TB] error responses");
    setSlave(1, 1, 1, 1, 1);
    r_resp = RESP_SLVERR; r_data = 32'h0BAD_0BAD;
    issueReq(1'b0, 32'h0000_2000, 4'hF, 32'h0, 10);
    waitResp(20);
    checkOutput("slverr_err", mem_err, 1);
    stepCycle();
    b_resp = RESP_DECERR;
    issueReq(1'b1, 32'h0000_2004, 4'hF, 32'h1111_2222, 10);
    waitResp(20);
    checkOutput("decerr_err", mem_err, 1);
    stepCycle();
    b_resp = RESP_OKAY; r_resp = RESP_OKAY;

    $display("[TB] pause and request together");
    pause_req = 1'b1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_3000;
    @(negedge clk);
    checkOutput("pause_no_gnt", mem_gnt, 0);
    stepCycle();
    @(negedge clk);
    checkOutput("pause_ack_on", pause_ack, 1);
    stepCycle();
    pause_req = 1'b0;
    @(negedge clk);
    checkOutput("pause_ack_hold", pause_ack, 1);
    stepCycle();
    @(negedge clk);
    checkOutput("pause_ack_off", pause_ack, 0);
    checkOutput("gnt_after_pause", mem_gnt, 1);
    stepCycle();
    mem_req = 1'b0;
    waitResp(20);
    stepCycle();

    $display("[TB] pause during read data phase");
    setSlave(1, 1, 1, 1, 0);
    issueReq(1'b0, 32'h0000_4000, 4'hF, 32'h0, 10);
    stepCycle();
    pause_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("pause_ack_busy", pause_ack, 0);
      stepCycle();
    end
    r_valid = 1'b1; r_data = 32'h1234_5678;
    waitResp(20);
    checkOutput("pause_rd_ack_at_rvalid", pause_ack, 0);
    checkOutput("pause_rd_rdata", mem_rdata, 32'h1234_5678);
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("pause_ack_after_rvalid", ack_rise_cycle > rvalid_cycle, 1);
    checkOutput("pause_ack_held", pause_ack, 1);
    pause_req = 1'b0;
    stepCycle();
    stepCycle();

    $display("[TB] reset during write");
    setSlave(0, 0, 1, 1, 1);
    issueReq(1'b1, 32'h0000_5000, 4'hF, 32'h5555_AAAA, 10);
    @(negedge clk);
    checkOutput("pre_rst_aw_valid", aw_valid, 1);
    checkOutput("pre_rst_w_valid", w_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_aw_valid", aw_valid, 0);
    checkOutput("async_rst_w_valid", w_valid, 0);
    checkOutput("async_rst_b_ready", b_ready, 0);
    stepCycle();
    stepCycle();
    rst = 1'b0;
    setSlave(1, 1, 1, 1, 1);
    snap = rv_cnt;
    for (int i = 0; i < 5; i++) stepCycle();
    checkOutput("rst_no_response", rv_cnt - snap, 0);
    r_data = 32'hA5A5_5A5A;
    issueReq(1'b0, 32'h0000_6000, 4'hF, 32'h0, 10);
    waitResp(20);
    checkOutput("post_rst_rdata", mem_rdata, 32'hA5A5_5A5A);
    stepCycle();

    $display("[TB] randomized traffic");
    gnt_seen = 0;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      stepCycle();
    end
    mem_req = 1'b0;
    pause_req = 1'b0;
    setSlave(1, 1, 1, 1, 1);
    for (int i = 0; i < 10; i++) stepCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
